// File: rtl/aes_misr_pkg.sv
// Shared types and helpers for the AES response MISR.
// Holds the run-state enum, the default Galois polynomial and the single-step
// MISR update used by the signature register.
package aes_misr_pkg;

  // Width of one AES block; the MISR step is defined over exactly this width
  localparam int MISR_W = 128;

  // x^128 + x^7 + x^2 + x + 1, with the implicit x^128 term dropped
  localparam logic [MISR_W-1:0] DEFAULT_POLY = 128'h87;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LAT = 2'd1,
    COMPACT  = 2'd2,
    DONE     = 2'd3
  } misr_state_e;

  // One Galois MISR step: shift left, fold the bit that fell out back in
  // through the taps, then mix in the incoming response word.
  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] data,
    input logic [MISR_W-1:0] poly
  );
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Signature register for the AES response MISR.
// Loads SEED on clear, otherwise advances by one Galois step whenever enabled.
// Clear has priority over enable so a restart always discards a coincident word.
module misr_reg
  import aes_misr_pkg::*;
#(
  parameter int                  NUM_BITS = MISR_W,
  parameter logic [NUM_BITS-1:0] SEED     = '0,
  parameter logic [NUM_BITS-1:0] POLY     = DEFAULT_POLY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic [NUM_BITS-1:0] i_data,
  output logic [NUM_BITS-1:0] o_sig
);

  logic [NUM_BITS-1:0] r_sig;
  logic [NUM_BITS-1:0] w_step;

  assign w_step = misr_step(r_sig, i_data, POLY);
  assign o_sig  = r_sig;

  // Signature state: reset to zero, reseed on clear, compact on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= SEED;
    end else if (i_enable) begin
      r_sig <= w_step;
    end
  end

endmodule

// File: rtl/aes_response_misr.sv
// Response-side MISR for aes_128 regression runs.
// Skips the pipeline fill (LATENCY issue-valid cycles), then compacts N
// ciphertexts into one signature and raises o_done until the next i_start.
// Optional feature: define AES_MISR_GOLDEN_CHECK_EN to add i_golden / o_pass,
// which compare the final signature against an expected value on entry to DONE.
module aes_response_misr
  import aes_misr_pkg::*;
#(
  parameter int                  NUM_BITS = 128,
  parameter int                  LATENCY  = 21,
  parameter int                  COUNT_W  = 32,
  parameter logic [NUM_BITS-1:0] SEED     = '0,
  parameter logic [NUM_BITS-1:0] POLY     = DEFAULT_POLY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [COUNT_W-1:0]  i_num_tests,
  input  logic                i_valid,
  input  logic [NUM_BITS-1:0] i_data,
`ifdef AES_MISR_GOLDEN_CHECK_EN
  input  logic [NUM_BITS-1:0] i_golden,
  output logic                o_pass,
`endif
  output logic [NUM_BITS-1:0] o_signature,
  output logic [COUNT_W-1:0]  o_count,
  output logic                o_busy,
  output logic                o_done
);

  // The latency counter only has to reach LATENCY-1
  localparam int                LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATENCY - 1);

  misr_state_e          r_state;
  misr_state_e          w_state_next;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   r_num_tests;
  logic [COUNT_W-1:0]   w_count_inc;
  logic                 w_absorb;
  logic                 w_lat_inc;
  logic [NUM_BITS-1:0]  w_signature;

  assign w_count_inc = r_count + COUNT_W'(1);

  // Next-state and per-cycle strobes; a start request overrides everything
  always_comb begin
    w_state_next = r_state;
    w_absorb     = 1'b0;
    w_lat_inc    = 1'b0;
    if (i_start) begin
      w_state_next = (i_num_tests == '0) ? DONE : WAIT_LAT;
    end else begin
      case (r_state)
        WAIT_LAT: begin
          if (i_valid) begin
            w_lat_inc = 1'b1;
            if (r_lat_cnt == LAT_LAST) begin
              w_state_next = COMPACT;
            end
          end
        end
        COMPACT: begin
          if (i_valid) begin
            w_absorb = 1'b1;
            if (w_count_inc == r_num_tests) begin
              w_state_next = DONE;
            end
          end
        end
        IDLE, DONE: begin
          w_state_next = r_state;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latency counter, absorbed-word counter and the latched run length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt   <= '0;
      r_count     <= '0;
      r_num_tests <= '0;
    end else if (i_start) begin
      r_lat_cnt   <= '0;
      r_count     <= '0;
      r_num_tests <= i_num_tests;
    end else begin
      if (w_lat_inc) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
      if (w_absorb) begin
        r_count <= w_count_inc;
      end
    end
  end

  misr_reg #(
    .NUM_BITS (NUM_BITS),
    .SEED     (SEED),
    .POLY     (POLY)
  ) u_misr_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_start),
    .i_enable (w_absorb),
    .i_data   (i_data),
    .o_sig    (w_signature)
  );

`ifdef AES_MISR_GOLDEN_CHECK_EN
  logic [NUM_BITS-1:0] w_sig_next;
  logic                w_enter_done;
  logic                r_pass;

  assign w_sig_next   = misr_step(w_signature, i_data, POLY);
  assign w_enter_done = (w_state_next == DONE) && (r_state != DONE);
  assign o_pass       = r_pass;

  // Golden compare: judged on the signature DONE is entered with, held until restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (i_start) begin
      r_pass <= (i_num_tests == '0) && (SEED == i_golden);
    end else if (w_enter_done) begin
      r_pass <= (w_sig_next == i_golden);
    end
  end
`endif

  assign o_signature = w_signature;
  assign o_count     = r_count;
  assign o_busy      = (r_state == WAIT_LAT) || (r_state == COMPACT);
  assign o_done      = (r_state == DONE);

endmodule
